// File: rtl/sha1_msg_ctrl_if.sv
// Block-in / digest-out bus between the SHA-1 message front-end, the
// sequencer and the digest consumer.
interface sha1_msg_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             abort;
  logic             blk_valid;
  logic             blk_ready;
  logic [511:0]     blk_data;
  logic             blk_last;
  logic             dig_valid;
  logic             dig_ready;
  logic [159:0]     digest;
  logic [CNT_W-1:0] blk_cnt;
  logic             busy;

  modport master (
    output abort, blk_valid, blk_data, blk_last, dig_ready,
    input  blk_ready, dig_valid, digest, blk_cnt, busy
  );

  modport slave (
    input  abort, blk_valid, blk_data, blk_last, dig_ready,
    output blk_ready, dig_valid, digest, blk_cnt, busy
  );
endinterface

// File: rtl/sha1_msg_ctrl.sv
// SHA-1 multi-block sequencer around a combinational compression datapath.
// Each block gets HASH_WAIT settle cycles; the chaining value lives here.

module sha1_block (
  input  logic [511:0] data,
  input  logic [159:0] sha_init,
  output logic [159:0] sha_res
);
  // One full 80-round compression plus the feed-forward add; the schedule
  // uses a rolling 16-word window.
  function automatic logic [159:0] compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, e, f, k, t;
    logic [3:0]  j;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    a = h[159:128];
    b = h[127:96];
    c = h[95:64];
    d = h[63:32];
    e = h[31:0];
    for (int i = 0; i < 80; i++) begin
      j = 4'(i);
      if (i >= 16) begin
        t    = w[4'(j + 4'd13)] ^ w[4'(j + 4'd8)] ^ w[4'(j + 4'd2)] ^ w[j];
        w[j] = {t[30:0], t[31]};
      end
      if (i < 20) begin
        f = (b & c) | (~b & d);
        k = 32'h5A827999;
      end else if (i < 40) begin
        f = b ^ c ^ d;
        k = 32'h6ED9EBA1;
      end else if (i < 60) begin
        f = (b & c) | (b & d) | (c & d);
        k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d;
        k = 32'hCA62C1D6;
      end
      t = {a[26:0], a[31:27]} + f + e + k + w[j];
      e = d;
      d = c;
      c = {b[1:0], b[31:2]};
      b = a;
      a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  assign sha_res = compress(sha_init, data);
endmodule

module sha1_msg_ctrl #(
  parameter int HASH_WAIT = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  sha1_msg_ctrl_if.slave    bus
);
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             first_q;
  logic             last_q;
  logic [159:0]     chain_q;
  logic [159:0]     digest_q;
  logic [511:0]     data_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] blk_cnt_q;
  logic [159:0]     sha_res;
  logic             accept;
  logic             settle;
  logic             release_dig;

  sha1_block u_sha (
    .data     (data_q),
    .sha_init (chain_q),
    .sha_res  (sha_res)
  );

  // NOTE: <= on every state register so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    settle      = 1'b0;
    release_dig = 1'b0;
    case (state_q)
      S_IDLE: if (bus.blk_valid) begin
        accept  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (wait_cnt == 8'd0) begin
        settle  = 1'b1;
        state_d = last_q ? S_DONE : S_IDLE;
      end
      S_DONE: if (bus.dig_ready) begin
        release_dig = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort outranks everything but reset; a coincident handshake is dropped.
    if (bus.abort) begin
      state_d     = S_IDLE;
      accept      = 1'b0;
      settle      = 1'b0;
      release_dig = 1'b0;
    end
  end

  // NOTE: the wide datapath registers are reset as well, because the defined
  // post-reset state (zero digest, zero chain) is observable on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q   <= 1'b1;
      chain_q   <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      wait_cnt  <= '0;
      digest_q  <= '0;
      blk_cnt_q <= '0;
    end else if (bus.abort) begin
      first_q <= 1'b1;
    end else begin
      if (accept) begin
        data_q   <= bus.blk_data;
        last_q   <= bus.blk_last;
        wait_cnt <= 8'(HASH_WAIT - 1);
        if (first_q) begin
          chain_q   <= IV;
          blk_cnt_q <= '0;
          first_q   <= 1'b0;
        end
      end
      if (state_q == S_WAIT && wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
      // chain_q only moves on the final settle cycle, keeping the datapath inputs stable.
      if (settle) begin
        chain_q   <= sha_res;
        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
        if (last_q) digest_q <= sha_res;
      end
      if (release_dig) first_q <= 1'b1;
    end
  end

  assign bus.blk_ready = (state_q == S_IDLE);
  assign bus.dig_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_WAIT) || (state_q == S_DONE);
  assign bus.digest    = digest_q;
  assign bus.blk_cnt   = blk_cnt_q;
endmodule

// File: tb/tb_sha1_msg_ctrl.sv
// Directed bench for sha1_msg_ctrl: FIPS 180 test messages, backpressure,
// abort and reset corners, on a HASH_WAIT=2 and a HASH_WAIT=1 instance.
module tb_sha1_msg_ctrl;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B    = {{15{32'h0}}, 32'h000001c0};
  localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_2     = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
  localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

  typedef struct {
    logic [511:0] blk0;
    logic [511:0] blk1;
    int           nblk;
    bit           sel;
    int           hold;
    bit           tied;
    logic [159:0] exp_dig;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  logic         clk = 1'b0;
  logic         rst;
  bit           sel;
  logic         abort;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         dig_ready;
  logic         blk_ready;
  logic         dig_valid;
  logic         busy;
  logic [159:0] digest;
  logic [15:0]  blk_cnt;

  int total = 0;
  int bad   = 0;
  int acc_count = 0;
  bit hs_seen = 1'b0;

  sha1_msg_ctrl_if #(.CNT_W(16)) bus2 ();
  sha1_msg_ctrl_if #(.CNT_W(16)) bus1 ();

  sha1_msg_ctrl #(.HASH_WAIT(2), .CNT_W(16)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  sha1_msg_ctrl #(.HASH_WAIT(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // sel steers stimulus to one instance and picks which one is observed.
  assign bus2.abort     = abort & ~sel;
  assign bus2.blk_valid = blk_valid & ~sel;
  assign bus2.blk_data  = blk_data;
  assign bus2.blk_last  = blk_last;
  assign bus2.dig_ready = dig_ready & ~sel;
  assign bus1.abort     = abort & sel;
  assign bus1.blk_valid = blk_valid & sel;
  assign bus1.blk_data  = blk_data;
  assign bus1.blk_last  = blk_last;
  assign bus1.dig_ready = dig_ready & sel;

  assign blk_ready = sel ? bus1.blk_ready : bus2.blk_ready;
  assign dig_valid = sel ? bus1.dig_valid : bus2.dig_valid;
  assign busy      = sel ? bus1.busy      : bus2.busy;
  assign digest    = sel ? bus1.digest    : bus2.digest;
  assign blk_cnt   = sel ? bus1.blk_cnt   : bus2.blk_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hs_seen <= blk_valid && blk_ready && !abort && !rst;
    if (blk_valid && blk_ready && !abort && !rst) acc_count <= acc_count + 1;
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  task automatic set_vec(input int idx, input logic [511:0] b0, input logic [511:0] b1,
                         input int nblk, input bit s, input int hold, input bit tied,
                         input logic [159:0] dig, input logic [15:0] cnt);
    vecs[idx].blk0    = b0;
    vecs[idx].blk1    = b1;
    vecs[idx].nblk    = nblk;
    vecs[idx].sel     = s;
    vecs[idx].hold    = hold;
    vecs[idx].tied    = tied;
    vecs[idx].exp_dig = dig;
    vecs[idx].exp_cnt = cnt;
  endtask

  // Presents one block and returns 1ns after the accepting edge.
  task automatic push(input logic [511:0] d, input logic last, input string name);
    int n;
    n = 0;
    blk_data  = d;
    blk_last  = last;
    blk_valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!hs_seen && n < 100);
    blk_valid = 1'b0;
    if (!hs_seen) timeout(name);
  endtask

  task automatic run_msg(input int idx);
    vec_t v;
    int   hw;
    int   start;
    v  = vecs[idx];
    hw = v.sel ? 1 : 2;
    sel       = v.sel;
    dig_ready = v.tied;
    for (int b = 0; b < v.nblk; b++) begin
      push((b == 0) ? v.blk0 : v.blk1, (b == v.nblk - 1), $sformatf("v%0d_accept%0d", idx, b));
      for (int k = 0; k < hw; k++) begin
        @(negedge clk);
        check($sformatf("v%0d_b%0d_wait%0d", idx, b, k), 160'({blk_ready, busy}), 160'(2'b01));
      end
      @(negedge clk);
      if (b < v.nblk - 1) begin
        check($sformatf("v%0d_b%0d_idle", idx, b), 160'({blk_ready, busy}), 160'(2'b10));
        check($sformatf("v%0d_b%0d_cnt", idx, b), 160'(blk_cnt), 160'(b + 1));
      end
    end
    check($sformatf("v%0d_dig_valid", idx), 160'(dig_valid), 160'(1'b1));
    check($sformatf("v%0d_digest", idx), digest, v.exp_dig);
    check($sformatf("v%0d_blk_cnt", idx), 160'(blk_cnt), 160'(v.exp_cnt));
    if (v.hold > 0) begin
      start     = acc_count;
      blk_data  = BLK_EMPTY;
      blk_last  = 1'b1;
      blk_valid = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        check($sformatf("v%0d_hold%0d_ctl", idx, h), 160'({dig_valid, blk_ready, busy}), 160'(3'b101));
        check($sformatf("v%0d_hold%0d_dig", idx, h), digest, v.exp_dig);
      end
      blk_valid = 1'b0;
      check($sformatf("v%0d_hold_no_accept", idx), 160'(acc_count), 160'(start));
    end
    dig_ready = 1'b1;
    @(posedge clk);
    #1;
    dig_ready = v.tied;
    @(negedge clk);
    check($sformatf("v%0d_released", idx), 160'({dig_valid, blk_ready, busy}), 160'(3'b010));
    check($sformatf("v%0d_cnt_kept", idx), 160'(blk_cnt), 160'(v.exp_cnt));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, 160'({blk_ready, dig_valid, busy}), 160'(3'b100));
    check({name, "_digest"}, digest, 160'(0));
    check({name, "_cnt"}, 160'(blk_cnt), 160'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; abort = 1'b0; blk_valid = 1'b0;
    blk_data = '0; blk_last = 1'b0; dig_ready = 1'b0;

    set_vec(0, BLK_ABC,   '0,     1, 1'b0, 10, 1'b0, DIG_ABC,   16'd1);
    set_vec(1, BLK_ABC,   '0,     1, 1'b0, 0,  1'b0, DIG_ABC,   16'd1);
    set_vec(2, BLK_2A,    BLK_2B, 2, 1'b0, 0,  1'b0, DIG_2,     16'd2);
    set_vec(3, BLK_ABC,   '0,     1, 1'b0, 0,  1'b0, DIG_ABC,   16'd1);
    set_vec(4, BLK_ABC,   '0,     1, 1'b1, 0,  1'b1, DIG_ABC,   16'd1);
    set_vec(5, BLK_EMPTY, '0,     1, 1'b1, 0,  1'b1, DIG_EMPTY, 16'd1);
    set_vec(6, BLK_ABC,   '0,     1, 1'b1, 0,  1'b1, DIG_ABC,   16'd1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_hw2");
    sel = 1'b1;
    #1 check_reset_outputs("reset_hw1");
    sel = 1'b0;

    // "abc" with backpressure, "abc" again (IV reload), then the two-block message.
    for (int i = 0; i < 3; i++) run_msg(i);

    // Abort mid-WAIT of a first block discards it; digest is retained.
    push(BLK_2A, 1'b0, "abort_wait_accept");
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_wait_ctl", 160'({blk_ready, dig_valid, busy}), 160'(3'b100));
    check("abort_wait_digest", digest, DIG_2);
    run_msg(3);

    // Abort coincident with a handshake drops the block.
    blk_data = BLK_ABC; blk_last = 1'b1; blk_valid = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 blk_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_hs_ctl", 160'({blk_ready, dig_valid, busy}), 160'(3'b100));
    run_msg(3);

    // Abort while the digest is being offered.
    push(BLK_ABC, 1'b1, "abort_done_accept");
    repeat (3) @(negedge clk);
    check("abort_done_pre", 160'(dig_valid), 160'(1'b1));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_done_ctl", 160'({blk_ready, dig_valid, busy}), 160'(3'b100));
    check("abort_done_digest", digest, DIG_ABC);
    check("abort_done_cnt", 160'(blk_cnt), 160'(1));

    // Reset in DONE, then in WAIT.
    push(BLK_ABC, 1'b1, "rst_done_accept");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_done");
    run_msg(3);
    push(BLK_2A, 1'b0, "rst_wait_accept");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_wait");
    run_msg(3);

    // HASH_WAIT=1 instance, consumer always ready.
    for (int i = 4; i < 7; i++) run_msg(i);
    dig_ready = 1'b0;
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha1_msg_ctrl.md
Name: sha1_msg_ctrl

Overview:
Sequencer that drives one instance of the combinational sha1_block compression datapath across a multi-block SHA-1 message. It accepts padded 512-bit blocks over a valid/ready handshake and gives the datapath a fixed number of settle cycles per block. It holds the 160-bit chaining value between blocks and presents the final digest on a valid/ready output. It sits between the padding/message front-end and the digest consumer.

Parameters:
HASH_WAIT, 2, cycles allowed for sha1_block to settle per block (multicycle path); legal range 1..255
CNT_W, 16, width of per-message block counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
abort  input  1  synchronous message abort; discards in-flight message
blk_valid  input  1  input block valid
blk_ready  output  1  controller can accept a block
blk_data  input  512  padded message block, first message byte at [511:504]; passed unchanged to sha1_block data
blk_last  input  1  block is final block of message; sampled with blk_data
dig_valid  output  1  digest valid
dig_ready  input  1  consumer accepts digest
digest  output  160  final hash, H0 at [159:128] ... H4 at [31:0]
blk_cnt  output  CNT_W  blocks completed in current message
busy  output  1  high in WAIT or DONE

Behaviour:
- Only one clock; reset synchronous, active-high, ports clk/rst.
- State after the reset edge: IDLE, first_q=1, chain_q=0, data_q=0, last_q=0, wait_cnt=0, digest=0, blk_cnt=0.
- Output values after the reset edge: blk_ready=1, dig_valid=0, busy=0.
- Fixed IV, same bit order as digest: 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0.
- sha1_block input connections: data=data_q, sha_init=chain_q.
- States: IDLE, WAIT, DONE. blk_ready = (state==IDLE); dig_valid = (state==DONE). All outputs come directly from registers or the state decode.
- IDLE, on blk_valid&blk_ready:
  - data_q<=blk_data; last_q<=blk_last.
  - If first_q: chain_q<=IV, blk_cnt<=0, first_q<=0.
  - wait_cnt<=HASH_WAIT-1; go to WAIT.
- WAIT: if wait_cnt!=0, decrement. If wait_cnt==0:
  - chain_q<=sha_res; blk_cnt<=blk_cnt+1 (wraps modulo 2^CNT_W).
  - If last_q: digest<=sha_res, go to DONE. Otherwise go to IDLE.
- DONE: hold digest and dig_valid until dig_ready. On dig_ready: go to IDLE, first_q<=1.
- Latency:
  - Accept edge T → chain update at edge T+HASH_WAIT.
  - For a last block, dig_valid is high in the cycle after edge T+HASH_WAIT.
  - Sustained throughput is one block per HASH_WAIT+1 cycles.
- blk_valid is ignored while not IDLE. The upstream source must hold data until ready.
- blk_cnt is stable in DONE and reads the message's block count. It is cleared only at the next message's first accept.
- abort (priority below rst, above everything else): state<=IDLE, first_q<=1, dig_valid drops next cycle.
  - digest and blk_cnt retain their old values.
  - abort in the same cycle as a blk_valid handshake: the block is dropped.
- rst mid-WAIT or mid-DONE: full reset values apply, and the in-flight block is lost.
- dig_ready while not DONE: ignored.
- blk_last=1 on the first block gives a single-block message. The IV is loaded and the digest is produced after one block.
- chain_q must not change while in WAIT before the final settle cycle. This keeps the sha1_block inputs stable across the multicycle path.

Test Plan:
1. Reset, then the padded "abc" block with blk_last=1, HASH_WAIT=2 → dig_valid visible after accept edge+2. digest=a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, blk_cnt=1.
2. Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" presented back-to-back → blk_ready low for HASH_WAIT cycles after each accept. digest=84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1, blk_cnt=2.
3. Backpressure: dig_ready held 0 for 10 cycles after scenario 1 → digest and dig_valid stable, blk_ready=0, a new blk_valid is not accepted. dig_ready=1 → IDLE next cycle, second "abc" message gives the identical digest (IV reloaded).
4. Abort: accept block 1 of scenario 2, assert abort during WAIT → IDLE and blk_ready=1 next cycle. Then the "abc" block gives a9993e36…, proving the chain was discarded.
5. rst asserted in DONE and in WAIT → all outputs at reset values after the edge. A subsequent "abc" message hashes correctly.
6. HASH_WAIT=1 with 3 consecutive single-block messages and dig_ready tied 1 → each accept is 2 cycles after the previous handshake completes. All three digests are correct, blk_cnt=1 each.
